// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator sequencer: AC opcode encodings, FSM state codes,
// instruction field widths and the decoded-flag bundle.
package ac_pkg;

  localparam logic [3:0] ADD   = 4'h0;
  localparam logic [3:0] LOAD  = 4'h2;
  localparam logic [3:0] STORE = 4'h4;
  localparam logic [3:0] JMP   = 4'h8;
  localparam logic [3:0] JZ    = 4'h9;
  localparam logic [3:0] HALT  = 4'hE;
  localparam logic [3:0] NO_OP = 4'hF;

  // Instruction word is {opcode, address}; the opcode sits directly above the address field.
  localparam int OPC_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  typedef struct packed {
    logic uses_operand;
    logic is_store;
    logic is_branch;
    logic is_halt;
  } dec_flags_t;

endpackage

// File: rtl/ac_seq_decode.sv
// Opcode classifier: maps a 4-bit opcode to the control flags the sequencer FSM branches on.
// Undefined opcodes produce no flags and therefore behave exactly like NO_OP.
module ac_seq_decode
  import ac_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_flags_t       flags
);

  always_comb begin
    flags = '0;
    case (opcode)
      ADD, LOAD: flags.uses_operand = 1'b1;
      STORE:     flags.is_store     = 1'b1;
      JMP, JZ:   flags.is_branch    = 1'b1;
      HALT:      flags.is_halt      = 1'b1;
      default:   flags = '0;
    endcase
  end

endmodule

// File: rtl/ac_sequencer.sv
// Program sequencer for the accumulator datapath: fetches and decodes instructions, reads
// operands, issues AC opcodes, and handles store, jump, jump-if-zero and halt.
module ac_sequencer
  import ac_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [ADDR_W+3:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        ac_opcode,
  output logic [DATA_W-1:0] ac_operand,
  input  logic [DATA_W-1:0] ac_out
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] field;
  logic [OPC_W-1:0]  opcode;
  logic              decode_live;
  dec_flags_t        flags;

  assign opcode = imem_rdata[ADDR_W +: OPC_W];
  assign field  = imem_rdata[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);

  ac_seq_decode u_decode (
    .opcode (opcode),
    .flags  (flags)
  );

  // Data strobes are driven from the instruction word during DECODE so the synchronous data
  // memory returns the operand in EXEC; abort or reset in that cycle suppresses them outright.
  assign decode_live = reset && !abort && (state == ST_DECODE);
  assign dmem_re     = decode_live && flags.uses_operand;
  assign dmem_we     = decode_live && flags.is_store;
  assign dmem_addr   = (dmem_re || dmem_we) ? field : '0;
  assign dmem_wdata  = ac_out;
  assign ac_operand  = (state == ST_EXEC) ? dmem_rdata : '0;

  always_comb begin
    pc_branch = pc_inc;
    if (flags.is_branch && ((opcode == JMP) || (ac_out == '0)))
      pc_branch = field;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      busy      <= 1'b0;
      done      <= 1'b0;
      imem_en   <= 1'b0;
      imem_addr <= '0;
      ac_opcode <= NO_OP;
    end else begin
      done      <= 1'b0;
      imem_en   <= 1'b0;
      imem_addr <= '0;
      ac_opcode <= NO_OP;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state     <= ST_FETCH;
              pc        <= RESET_PC;
              busy      <= 1'b1;
              imem_en   <= 1'b1;
              imem_addr <= RESET_PC;
            end
          end
          ST_FETCH: state <= ST_DECODE;
          ST_DECODE: begin
            if (flags.uses_operand) begin
              state     <= ST_EXEC;
              ac_opcode <= opcode;
            end else if (flags.is_halt) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              pc        <= pc_branch;
              imem_en   <= 1'b1;
              imem_addr <= pc_branch;
            end
          end
          ST_EXEC: begin
            state     <= ST_FETCH;
            pc        <= pc_inc;
            imem_en   <= 1'b1;
            imem_addr <= pc_inc;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac_sequencer.sv
// Scoreboard bench for ac_sequencer: directed programs push expected fetch/AC/write/done
// events, and a monitor pops and compares them whenever the DUT presents one.
module tb_ac_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [1:0] EV_FETCH = 2'd0;
  localparam logic [1:0] EV_AC    = 2'd1;
  localparam logic [1:0] EV_WR    = 2'd2;
  localparam logic [1:0] EV_DONE  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, imem_en, dmem_re, dmem_we;
  logic [ADDR_W-1:0] imem_addr, dmem_addr;
  logic [ADDR_W+3:0] imem_rdata;
  logic [DATA_W-1:0] dmem_rdata, dmem_wdata, ac_operand;
  logic [DATA_W-1:0] ac_out = '0;
  logic [3:0]        ac_opcode;

  logic [ADDR_W+3:0] imem [0:255];
  logic [DATA_W-1:0] dmem [0:255];
  ev_t               expq[$];
  int                checks = 0;
  int                errors = 0;

  ac_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .ac_opcode  (ac_opcode),
    .ac_operand (ac_operand),
    .ac_out     (ac_out)
  );

  always #5 clk = ~clk;

  // Synchronous memories and a behavioural accumulator that only knows LOAD and ADD.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
    if (ac_opcode == 4'h2) ac_out <= ac_operand;
    else if (ac_opcode == 4'h0) ac_out <= ac_out + ac_operand;
  end

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    expq.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d a=%0h b=%0h, required no event", kind, a, b);
    end else begin
      e = expq.pop_front();
      checkOutput("ev_kind", 32'(kind), 32'(e.kind));
      checkOutput("ev_a", a, e.a);
      checkOutput("ev_b", b, e.b);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_en) observe(EV_FETCH, 32'(imem_addr), 32'd0);
        if (ac_opcode != 4'hF) observe(EV_AC, 32'(ac_opcode), ac_operand);
        if (dmem_we) observe(EV_WR, 32'(dmem_addr), dmem_wdata);
        if (done) observe(EV_DONE, 32'd0, 32'd0);
      end
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = ins(4'hF, 8'h00);
      dmem[i] = '0;
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic abortInCycle(input int n);
    repeat (n - 1) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic runUntilDone(input string name, input int expCycles);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 60);
    checkOutput(name, 32'(k), 32'(expCycles));
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1 checkOutput(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearMem();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_opcode", 32'(ac_opcode), 32'hF);
    checkOutput("rst_operand", ac_operand, 32'd0);
    checkOutput("rst_strobes", {29'd0, imem_en, dmem_re, dmem_we}, 32'd0);
    checkOutput("rst_addrs", {16'd0, imem_addr, dmem_addr}, 32'd0);

    // LOAD 5; ADD 6; STORE 7; HALT
    imem[0] = ins(4'h2, 8'd5);
    imem[1] = ins(4'h0, 8'd6);
    imem[2] = ins(4'h4, 8'd7);
    imem[3] = ins(4'hE, 8'd0);
    dmem[5] = 32'd10;
    dmem[6] = 32'd32;
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_AC,    32'h2, 32'd10);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    pushExp(EV_AC,    32'h0, 32'd32);
    pushExp(EV_FETCH, 32'd2, 32'd0);
    pushExp(EV_WR,    32'd7, 32'd42);
    pushExp(EV_FETCH, 32'd3, 32'd0);
    pushExp(EV_DONE,  32'd0, 32'd0);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 applyStimulus();
    checkOutput("start_imem_en", 32'(imem_en), 32'd1);
    checkOutput("start_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("start_busy", 32'(busy), 32'd1);
    runUntilDone("prog1_done_latency", 11);
    #1 checkOutput("prog1_busy_after", 32'(busy), 32'd0);
    settle("prog1_queue");

    // JZ taken: LOAD 1 (=0); JZ 6; HALT at 2 and 6
    clearMem();
    imem[0] = ins(4'h2, 8'd1);
    imem[1] = ins(4'h9, 8'd6);
    imem[2] = ins(4'hE, 8'd0);
    imem[6] = ins(4'hE, 8'd0);
    dmem[1] = 32'd0;
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_AC,    32'h2, 32'd0);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    pushExp(EV_FETCH, 32'd6, 32'd0);
    pushExp(EV_DONE,  32'd0, 32'd0);
    applyStimulus();
    runUntilDone("jz_taken_latency", 8);
    settle("jz_taken_queue");

    dmem[1] = 32'd3;
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_AC,    32'h2, 32'd3);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    pushExp(EV_FETCH, 32'd2, 32'd0);
    pushExp(EV_DONE,  32'd0, 32'd0);
    applyStimulus();
    runUntilDone("jz_not_taken_latency", 8);
    settle("jz_not_taken_queue");

    // JMP 255; NO_OP at 255 wraps to 0; abort while fetching 0 again
    clearMem();
    imem[0] = ins(4'h8, 8'd255);
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_FETCH, 32'd255, 32'd0);
    pushExp(EV_FETCH, 32'd0, 32'd0);
    applyStimulus();
    abortInCycle(5);
    checkOutput("wrap_abort_busy", 32'(busy), 32'd0);
    checkOutput("wrap_abort_imem_en", 32'(imem_en), 32'd0);
    settle("wrap_queue");

    // Abort during EXEC of ADD: AC updated exactly once, no done
    clearMem();
    imem[0] = ins(4'h2, 8'd5);
    imem[1] = ins(4'h0, 8'd6);
    imem[2] = ins(4'hE, 8'd0);
    dmem[5] = 32'd10;
    dmem[6] = 32'd32;
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_AC,    32'h2, 32'd10);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    pushExp(EV_AC,    32'h0, 32'd32);
    applyStimulus();
    abortInCycle(6);
    checkOutput("exec_abort_opcode", 32'(ac_opcode), 32'hF);
    checkOutput("exec_abort_busy", 32'(busy), 32'd0);
    checkOutput("exec_abort_done", 32'(done), 32'd0);
    checkOutput("exec_abort_ac", ac_out, 32'd42);
    settle("exec_abort_queue");

    // Abort during DECODE of STORE: no write may appear
    clearMem();
    imem[0] = ins(4'h2, 8'd5);
    imem[1] = ins(4'h4, 8'd7);
    imem[2] = ins(4'hE, 8'd0);
    dmem[5] = 32'd10;
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_AC,    32'h2, 32'd10);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    applyStimulus();
    abortInCycle(5);
    checkOutput("store_abort_busy", 32'(busy), 32'd0);
    settle("store_abort_queue");

    // Undefined opcode 7 acts as NO_OP; start while busy is ignored
    clearMem();
    imem[0] = ins(4'h7, 8'h33);
    imem[1] = ins(4'hE, 8'd0);
    pushExp(EV_FETCH, 32'd0, 32'd0);
    pushExp(EV_FETCH, 32'd1, 32'd0);
    pushExp(EV_DONE,  32'd0, 32'd0);
    applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    checkOutput("undef_no_strobes", {30'd0, dmem_re, dmem_we}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("undef_busy", 32'(busy), 32'd1);
    runUntilDone("undef_done_latency", 3);
    settle("undef_queue");

    // start and abort together in IDLE: stay idle
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    checkOutput("start_abort_imem_en", 32'(imem_en), 32'd0);
    settle("start_abort_queue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
